// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute/memory stage and a byte-addressed data memory.
// Loads are sign/zero-extended; byte/half stores read-modify-write a full 4-byte memory word.
module lsu_mem_master #(
    parameter logic [31:0] START_ADDR = 32'h01000000,
    parameter int unsigned MEM_SIZE   = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_error,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_w_enable,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [31:0] LAST_ADDR = START_ADDR + 32'(MEM_SIZE) - 32'd4;

    state_t      state, state_nxt;
    logic        accept, req_err;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [15:0] r_wdata_lo;

    logic        rsp_valid_d, rsp_error_d, mem_w_enable_d;
    logic [31:0] rsp_rdata_d, mem_addr_d, mem_wdata_d;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns);
        logic [31:0] r;
        case (sz)
            2'b00:   r = uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'b01:   r = uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) r[7:0]  = d[7:0];
        else             r[15:0] = d;
        return r;
    endfunction

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (req_addr < START_ADDR || req_addr > LAST_ADDR) req_err = 1'b1;
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_size       <= '0;
            r_wdata_lo   <= '0;
            rsp_valid    <= 1'b0;
            rsp_error    <= 1'b0;
            rsp_rdata    <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_w_enable <= 1'b0;
        end else begin
            state        <= state_nxt;
            rsp_valid    <= rsp_valid_d;
            rsp_error    <= rsp_error_d;
            rsp_rdata    <= rsp_rdata_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            mem_w_enable <= mem_w_enable_d;
            if (accept) begin
                r_we       <= req_we;
                r_uns      <= req_unsigned;
                r_size     <= req_size;
                r_wdata_lo <= req_wdata[15:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                          state_nxt = RESP;
                    else if (req_we && req_size == 2'b10) state_nxt = WRITE;
                    else                                  state_nxt = READ;
                end
            end
            READ:    state_nxt = r_we ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; the read word is consumed directly
    // at the end of READ, either extended into rsp_rdata or merged into mem_wdata.
    always_comb begin
        rsp_valid_d    = 1'b0;
        rsp_error_d    = 1'b0;
        rsp_rdata_d    = '0;
        mem_addr_d     = mem_addr;
        mem_wdata_d    = mem_wdata;
        mem_w_enable_d = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        mem_addr_d = req_addr;
                        if (req_we && req_size == 2'b10) begin
                            mem_wdata_d    = req_wdata;
                            mem_w_enable_d = 1'b1;
                        end
                    end
                end
            end
            READ: begin
                if (r_we) begin
                    mem_wdata_d    = store_merge(mem_rdata, r_size, r_wdata_lo);
                    mem_w_enable_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_ext(mem_rdata, r_size, r_uns);
                end
            end
            WRITE:   rsp_valid_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: vector table plus scoreboard of
// expected responses and write-enable cycles, and hand sequences for reset/back-to-back.
module tb_lsu_mem_master;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error, mem_w_enable;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    lsu_mem_master #(.START_ADDR(32'h01000000), .MEM_SIZE(1048576)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_enable(mem_w_enable),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   weq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Memory window: only the low address byte is decoded (START_ADDR is 256-aligned)
    logic [7:0] mem [0:255];
    logic [7:0] mo;
    assign mo = mem_addr[7:0];
    assign mem_rdata = {mem[8'(mo + 8'd3)], mem[8'(mo + 8'd2)], mem[8'(mo + 8'd1)], mem[mo]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_w_enable) begin
            mem[mo]             <= mem_wdata[7:0];
            mem[8'(mo + 8'd1)]  <= mem_wdata[15:8];
            mem[8'(mo + 8'd2)]  <= mem_wdata[23:16];
            mem[8'(mo + 8'd3)]  <= mem_wdata[31:24];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   wc;
        if (rst_n) begin
            if (rsp_valid) begin
                if (sbq.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                else begin
                    e = sbq.pop_front();
                    check("rsp_error", 32'(rsp_error), 32'(e.err));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end
            if (mem_w_enable) begin
                if (weq.size() == 0) check("we_unexpected", 32'(mem_w_enable), 32'd0);
                else begin
                    wc = weq.pop_front();
                    check("we_cycle", 32'(cyc), 32'(wc));
                end
            end
        end
    end

    // Call just after a posedge; returns the handshake cycle.
    task automatic send(input vec_t v, input bit keep, input bit push, output int acc);
        int n;
        int lat;
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        acc = cyc;
        if (v.err)                      lat = 1;
        else if (v.we && v.size != 2'd2) lat = 3;
        else                            lat = 2;
        if (push) begin
            sbq.push_back('{v.err, v.rdata, cyc + lat});
            if (v.we && !v.err) weq.push_back(cyc + ((v.size == 2'd2) ? 1 : 2));
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || weq.size() != 0) && n < 30) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0 || weq.size() != 0)
            check("drain_timeout", 32'(sbq.size() + weq.size()), 32'd0);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},  32'(req_ready), 32'd1);
        check({tag, "_rsp_v"},  32'(rsp_valid), 32'd0);
        check({tag, "_rsp_e"},  32'(rsp_error), 32'd0);
        check({tag, "_rdata"},  rsp_rdata, 32'd0);
        check({tag, "_maddr"},  mem_addr, 32'd0);
        check({tag, "_mwdata"}, mem_wdata, 32'd0);
        check({tag, "_we"},     32'(mem_w_enable), 32'd0);
    endtask

    vec_t vecs[20];
    vec_t v;
    int   acc1, acc2;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h0D; mem[8'h11] = 8'hF0; mem[8'h12] = 8'hAD; mem[8'h13] = 8'h8B;

        //          we    size  uns   addr           wdata          err   rdata
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h01000013, 32'h0,         1'b0, 32'hFFFFFF8B};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h01000013, 32'h0,         1'b0, 32'h0000008B};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h01000010, 32'h0,         1'b0, 32'hFFFFF00D};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h01000010, 32'h0,         1'b0, 32'h0000F00D};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h01000010, 32'h0,         1'b0, 32'h8BADF00D};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h01000011, 32'h000000AA,  1'b0, 32'h0};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h01000010, 32'h0,         1'b0, 32'h8BADAA0D};
        vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h01000020, 32'h12345678,  1'b0, 32'h0};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h01000020, 32'h0,         1'b0, 32'h12345678};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h01000022, 32'hFFFFBEEF,  1'b0, 32'h0};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h01000020, 32'h0,         1'b0, 32'hBEEF5678};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h01000022, 32'h0,         1'b0, 32'hFFFFBEEF};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h01000020, 32'h0,         1'b0, 32'h00000078};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h01000022, 32'h0,         1'b1, 32'h0};
        vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h01000021, 32'h5555,      1'b1, 32'h0};
        vecs[15] = '{1'b0, 2'd3, 1'b0, 32'h01000010, 32'h0,         1'b1, 32'h0};
        vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h00FFFFFC, 32'h0,         1'b1, 32'h0};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h010FFFFC, 32'h0,         1'b0, 32'h0};
        vecs[18] = '{1'b0, 2'd0, 1'b0, 32'h010FFFFD, 32'h0,         1'b1, 32'h0};
        vecs[19] = '{1'b1, 2'd2, 1'b0, 32'h01100000, 32'hFFFFFFFF,  1'b1, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            send(vecs[i], 1'b0, 1'b1, acc1);
            drain();
        end

        // Back-to-back: request held valid, second taken on the first IDLE cycle
        v = '{1'b0, 2'd2, 1'b0, 32'h01000020, 32'h0, 1'b0, 32'hBEEF5678};
        send(v, 1'b1, 1'b1, acc1);
        v = '{1'b1, 2'd2, 1'b0, 32'h01000040, 32'hCAFEF00D, 1'b0, 32'h0};
        send(v, 1'b0, 1'b1, acc2);
        check("pipe_accept", 32'(acc2), 32'(acc1 + 3));
        drain();
        v = '{1'b0, 2'd2, 1'b0, 32'h01000040, 32'h0, 1'b0, 32'hCAFEF00D};
        send(v, 1'b0, 1'b1, acc1);
        drain();

        // Asynchronous reset while in WRITE: the store is dropped
        v = '{1'b1, 2'd2, 1'b0, 32'h01000030, 32'hDEADBEEF, 1'b0, 32'h0};
        send(v, 1'b0, 1'b0, acc1);
        check("we_before_rst", 32'(mem_w_enable), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("we_async_drop", 32'(mem_w_enable), 32'd0);
        check_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_word", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'd0);
        v = '{1'b0, 2'd2, 1'b0, 32'h01000030, 32'h0, 1'b0, 32'h0};
        send(v, 1'b0, 1'b1, acc1);
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
